tone_detector: RTL and testbench
================================

# tone_detector

Measures the half-period of an incoming square-wave tone and maps it back to the 16-entry piano note index that the buzzer generator uses (C4..D6). It is the receive end of the buzzer tone interface: an external buzzer line or comparator output comes in on `tone_in`, and a debounced note index plus valid flag come out. Those outputs feed the record/learn path in place of the key scanner.

## Interface

Parameters:
- `TOL_SHIFT`, default 5: match tolerance is ±(table entry >> TOL_SHIFT), about ±3.1 %.
- `STABLE_CNT`, default 4: number of consecutive matching half-periods needed to acquire a note.
- `TIMEOUT`, default 400000: clock cycles without an edge before the input is declared silent.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: asynchronous, active-low reset.
- `tone_in` in 1: asynchronous square-wave input.
- `note_valid` out 1: a confirmed note is present.
- `note` out 5: confirmed note index 0..15. Meaningful only while `note_valid`=1.
- `note_changed` out 1: one-cycle pulse when `note_valid` rises.

## Operation

- **Input conditioning:** `tone_in` passes through a 2-FF synchronizer and then edge detection. Both rising and falling edges count as half-period boundaries.
- **Measurement counter:** `hp_cnt`, 32 bits.
  - Increments every cycle and saturates at `TIMEOUT`.
  - Cleared to 1 on every edge.
  - On each edge the value before clearing is latched into `hp_meas`.
- **Arming:**
  - The `armed` flag is 0 after reset and after a timeout.
  - An edge while unarmed sets `armed` and starts counting; it is not evaluated.
  - An edge while armed starts evaluation of `hp_meas`.
- **FSM states:**
  - IDLE → SCAN on an armed edge.
  - SCAN compares `hp_meas` against one table entry per cycle, index 0..15, and exits on the first hit or after index 15.
  - SCAN → UPDATE, then UPDATE → IDLE.
- **Hit rule:** index i is a hit when |hp_meas − HALF_PERIOD[i]| ≤ HALF_PERIOD[i] >> TOL_SHIFT. Compute the difference unsigned as max − min; no signed arithmetic.
- **UPDATE, hit with index == candidate:** stable count increments and saturates at `STABLE_CNT`. When it reaches `STABLE_CNT` with `note_valid`=0, set `note_valid`=1, `note`=candidate, and pulse `note_changed`.
- **UPDATE, hit with a different index:** candidate = new index, count = 1, `note_valid` = 0.
- **UPDATE, no hit:** count = 0, `note_valid` = 0.
- **Edge during SCAN:** aborts the scan and is treated as a no-hit. The new measurement still starts normally.
- **Timeout:** when `hp_cnt` reaches `TIMEOUT`, clear `note_valid`, the stable count and `armed`.
- **Half-period table (cycles, index 0..15):**
  - 0..7: 191570, 170648, 151975, 143266, 127551, 113636, 101419, 95602
  - 8..15: 85178, 75872, 71633, 63775, 56818, 50658, 47801, 42589

## Timing

- **Reset values:** `note_valid`=0, `note`=0, `note_changed`=0, `hp_cnt`=0, `armed`=0, FSM in IDLE, stable count 0.
- **Edge detect latency:** 3 cycles from a `tone_in` transition to the internal edge pulse (2 synchronizer stages + 1 detector stage), without the filter.
- **Scan latency:** the UPDATE cycle is at most 17 cycles after the edge pulse.
  - Outputs register in UPDATE and are visible the next cycle.
  - Worst case, a transition to `note`/`note_valid` is visible within 21 cycles.
- **`note_changed`:** exactly one cycle wide, coincident with the first cycle of `note_valid`=1.
- **Timeout vs. edge:** `note_valid` falls exactly `TIMEOUT` cycles after the last edge pulse. An edge in the same cycle as the timeout wins: it clears the counter and no timeout occurs.
- **Reset mid-operation:** reset asserted during SCAN or measurement returns everything to reset values immediately. The first edge after reset only arms the detector.

## Configuration

- **`TONE_DETECT_GLITCH_FILTER_EN`:** when defined, the synchronized input must hold a new level for 3 consecutive cycles before an edge is accepted. Shorter pulses are ignored, and edge latency becomes 6 cycles.
- **Macro undefined:** every synchronized level change is an edge.

## Structure

- **Shared package `piano_pkg`:**
  - `NUM_NOTES`=16 and `CLK_HZ`=100_000_000.
  - The `HALF_PERIOD` constant array, shared with the buzzer generator.
  - The 5-bit `note_idx_t` typedef.
- **Sub-module `tone_edge_sync`:** synchronizer, optional glitch filter and edge pulse. The measurement counter, FSM and stability logic stay in `tone_detector`.

## Test plan

- **A4 acquire:** square wave, half-period 113636 cycles, 6 half-periods → `note_valid` rises after the 5th edge (4 evaluated matches) + ≤21 cycles, `note`=5, exactly one `note_changed` pulse.
- **Silence:** after A4 is valid, hold `tone_in` constant → `note_valid` falls exactly 400000 cycles after the last edge pulse.
- **Off-table tone:** half-period 108000 cycles → `note_valid` stays 0 throughout.
- **Note change:** C5 (95602) valid, then switch to D5 (85178) → `note_valid` drops at the first D5 UPDATE and re-acquires with `note`=8 after 4 D5 matches.
- **Reset mid-scan:** assert `rst` low during SCAN → all outputs 0 immediately; after release, the first edge does not count toward `STABLE_CNT`.
- **Glitch filter, macro defined:** a 1-cycle low pulse in an E4 tone → no edge, `note` stays 2 and valid. With the macro undefined → `note_valid` drops.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared piano constants: the note count, the clock rate and the half-period table
// used by the buzzer generator and the tone detector. Also the detector's FSM state type.
package piano_pkg;

  localparam int NUM_NOTES = 16;
  localparam int CLK_HZ    = 100_000_000;

  typedef logic [4:0] note_idx_t;

  // Half-period of each note in CLK_HZ cycles, C4 (index 0) .. D6 (index 15)
  localparam logic [31:0] HALF_PERIOD [NUM_NOTES] = '{
    32'd191570, 32'd170648, 32'd151975, 32'd143266,
    32'd127551, 32'd113636, 32'd101419, 32'd95602,
    32'd85178,  32'd75872,  32'd71633,  32'd63775,
    32'd56818,  32'd50658,  32'd47801,  32'd42589
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_UPDATE
  } det_state_t;

endpackage

// File: rtl/tone_edge_sync.sv
// Synchronises tone_in and emits a one-cycle pulse on every accepted level change.
// TONE_DETECT_GLITCH_FILTER_EN adds a 3-sample hold requirement before a change is accepted.
module tone_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic tone_edge
);

  logic sync_p0, sync_p1, level_p2;
`ifdef TONE_DETECT_GLITCH_FILTER_EN
  logic [1:0] hold_cnt;
  logic       accept_p3;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      level_p2  <= 1'b0;
      tone_edge <= 1'b0;
`ifdef TONE_DETECT_GLITCH_FILTER_EN
      hold_cnt  <= '0;
      accept_p3 <= 1'b0;
`endif
    end else begin
      sync_p0 <= tone_in;
      sync_p1 <= sync_p0;
`ifdef TONE_DETECT_GLITCH_FILTER_EN
      // A new level must differ from the accepted one on three consecutive samples
      if (sync_p1 == level_p2) begin
        hold_cnt  <= '0;
        accept_p3 <= 1'b0;
      end else if (hold_cnt == 2'd2) begin
        level_p2  <= sync_p1;
        hold_cnt  <= '0;
        accept_p3 <= 1'b1;
      end else begin
        hold_cnt  <= hold_cnt + 2'd1;
        accept_p3 <= 1'b0;
      end
      tone_edge <= accept_p3;
`else
      level_p2  <= sync_p1;
      tone_edge <= sync_p1 ^ level_p2;
`endif
    end
  end

endmodule

// File: rtl/tone_detector.sv
// Measures tone_in half-periods and maps them to a debounced piano note index.
// Optional TONE_DETECT_GLITCH_FILTER_EN enables the input glitch filter in tone_edge_sync.
module tone_detector
  import piano_pkg::*;
#(
  parameter int TOL_SHIFT  = 5,
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 400000,
  parameter int HP_SHIFT   = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      tone_in,
  output logic      note_valid,
  output note_idx_t note,
  output logic      note_changed
);

  localparam int              CNT_W     = $clog2(STABLE_CNT + 1);
  localparam logic [31:0]     TIMEOUT_C = 32'(TIMEOUT);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CNT - 1);
  localparam logic [3:0]      LAST_IDX  = 4'(NUM_NOTES - 1);

  logic             tone_edge;
  logic             armed;
  logic             timeout_hit;
  logic             eval_start;
  logic             scan_hit;
  logic [31:0]      hp_cnt;
  logic [31:0]      hp_meas;
  det_state_t       state;
  logic [3:0]       scan_idx;
  logic [3:0]       hit_idx;
  logic             hit_found;
  logic [3:0]       cand;
  logic [CNT_W-1:0] stable_cnt;

  // HP_SHIFT scales the table for builds clocked at CLK_HZ >> HP_SHIFT
  function automatic logic half_period_match(input logic [31:0] meas,
                                             input logic [31:0] entry);
    logic [31:0] ref_hp;
    logic [31:0] diff;
    ref_hp = entry >> HP_SHIFT;
    diff   = (meas > ref_hp) ? (meas - ref_hp) : (ref_hp - meas);
    return diff <= (ref_hp >> TOL_SHIFT);
  endfunction

  tone_edge_sync u_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .tone_in   (tone_in),
    .tone_edge (tone_edge)
  );

  assign timeout_hit = !tone_edge && (hp_cnt == TIMEOUT_C - 32'd1);
  assign eval_start  = tone_edge && armed;
  assign scan_hit    = half_period_match(hp_meas, HALF_PERIOD[scan_idx]);

  // Measurement stage: half-period counter and arming
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hp_cnt <= '0;
      armed  <= 1'b0;
    end else if (tone_edge) begin
      hp_cnt <= 32'd1;
      armed  <= 1'b1;
    end else begin
      if (hp_cnt < TIMEOUT_C) hp_cnt <= hp_cnt + 32'd1;
      if (timeout_hit) armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tone_edge) hp_meas <= hp_cnt;
  end

  // Evaluation stage: table scan, stability tracking and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      scan_idx     <= '0;
      hit_idx      <= '0;
      hit_found    <= 1'b0;
      cand         <= '0;
      stable_cnt   <= '0;
      note_valid   <= 1'b0;
      note         <= '0;
      note_changed <= 1'b0;
    end else begin
      note_changed <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (eval_start) begin
            state    <= ST_SCAN;
            scan_idx <= '0;
          end
        end
        ST_SCAN: begin
          if (tone_edge) begin
            hit_found <= 1'b0;
            state     <= ST_UPDATE;
          end else if (scan_hit) begin
            hit_found <= 1'b1;
            hit_idx   <= scan_idx;
            state     <= ST_UPDATE;
          end else if (scan_idx == LAST_IDX) begin
            hit_found <= 1'b0;
            state     <= ST_UPDATE;
          end else begin
            scan_idx <= scan_idx + 4'd1;
          end
        end
        ST_UPDATE: begin
          state <= ST_IDLE;
          if (!hit_found) begin
            stable_cnt <= '0;
            note_valid <= 1'b0;
          end else if (hit_idx != cand) begin
            cand       <= hit_idx;
            stable_cnt <= CNT_W'(1);
            note_valid <= 1'b0;
          end else begin
            if (stable_cnt != STABLE_C) stable_cnt <= stable_cnt + CNT_W'(1);
            if ((stable_cnt >= STABLE_M1) && !note_valid) begin
              note_valid   <= 1'b1;
              note         <= {1'b0, cand};
              note_changed <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (timeout_hit) begin
        stable_cnt <= '0;
        note_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector: table-driven note sequences, hand-written corner cases and
// randomised half-periods checked against an evaluation-history reference model.
`timescale 1ns/1ps
module tb_tone_detector;

  localparam int TIMEOUT   = 2000;
  localparam int HP_SHIFT  = 8;
  localparam int STABLE    = 4;
  localparam int TOL_SHIFT = 5;
  localparam int CHECK_DLY = 25;
`ifdef TONE_DETECT_GLITCH_FILTER_EN
  localparam int EDGE_LAT     = 6;
  localparam int EXP_GLITCH_V = 1;
`else
  localparam int EDGE_LAT     = 3;
  localparam int EXP_GLITCH_V = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tone_in = 1'b0;
  logic       note_valid;
  logic       note_changed;
  logic [4:0] note;

  int n_cmp = 0;
  int n_bad = 0;
  int chg_cnt = 0;
  int chg_mark = 0;
  int chg_misplaced = 0;
  logic prev_valid = 1'b0;

  // Note half-periods at 100 MHz, C4..D6
  int full_hp [16] = '{191570, 170648, 151975, 143266, 127551, 113636, 101419, 95602,
                       85178, 75872, 71633, 63775, 56818, 50658, 47801, 42589};

  typedef struct {
    int gap;
    bit ev;
    int en;
    int echg;
  } vec_t;
  vec_t vecs [22];

  int  hist [$];
  bit  m_armed;
  bit  m_valid;

  tone_detector #(
    .TOL_SHIFT  (TOL_SHIFT),
    .STABLE_CNT (STABLE),
    .TIMEOUT    (TIMEOUT),
    .HP_SHIFT   (HP_SHIFT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tone_in      (tone_in),
    .note_valid   (note_valid),
    .note         (note),
    .note_changed (note_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (note_changed) begin
      chg_cnt++;
      if (!note_valid || prev_valid) chg_misplaced++;
    end
    prev_valid = note_valid;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int lookup(input int gap);
    int e;
    int tol;
    int d;
    for (int i = 0; i < 16; i++) begin
      e   = full_hp[i] >> HP_SHIFT;
      tol = e >> TOL_SHIFT;
      d   = (gap > e) ? gap - e : e - gap;
      if (d <= tol) return i;
    end
    return -1;
  endfunction

  // Valid when the last STABLE evaluations since arming all hit the same note
  task automatic model_edge(input int gap_before, output bit v, output int n, output int chg);
    bit was;
    if (gap_before >= TIMEOUT) begin
      hist.delete();
      m_armed = 1'b0;
      m_valid = 1'b0;
    end
    was = m_valid;
    if (!m_armed) m_armed = 1'b1;
    else hist.push_back(lookup(gap_before));
    m_valid = 1'b0;
    if (hist.size() >= STABLE) begin
      m_valid = (hist[hist.size()-1] >= 0);
      for (int k = 1; k < STABLE; k++)
        if (hist[hist.size()-1-k] != hist[hist.size()-1]) m_valid = 1'b0;
    end
    v   = m_valid;
    n   = m_valid ? hist[hist.size()-1] : 0;
    chg = (m_valid && !was) ? 1 : 0;
  endtask

  // Called at a negedge; toggles the tone, checks outputs, then waits out the gap
  task automatic toggle(input string name, input int gap, input bit ev, input int en,
                        input int echg);
    tone_in = ~tone_in;
    repeat (CHECK_DLY) @(negedge clk);
    cmp({name, " valid"}, int'(note_valid), int'(ev));
    if (ev) cmp({name, " note"}, int'(note), en);
    cmp({name, " pulses"}, chg_cnt - chg_mark, echg);
    chg_mark = chg_cnt;
    if (gap > CHECK_DLY) repeat (gap - CHECK_DLY) @(negedge clk);
  endtask

  initial begin
    bit mv;
    int mn;
    int mc;
    int prev_gap;
    int gap;
    int cur;
    int e;
    int tol;
    int r;

    // A4 acquire (443 = 113636 >> 8)
    for (int i = 0; i < 6; i++) vecs[i] = '{443, (i >= 4), 5, (i == 4) ? 1 : 0};
    vecs[5].gap = CHECK_DLY;
    // Off-table tone (108000 >> 8)
    for (int i = 6; i < 12; i++) vecs[i] = '{421, 1'b0, 0, 0};
    vecs[11].gap = TIMEOUT + 50;
    // C5 (373) acquire, then D5 (332) takes over
    vecs[12] = '{373, 1'b0, 0, 0};
    vecs[13] = '{373, 1'b0, 0, 0};
    vecs[14] = '{373, 1'b0, 0, 0};
    vecs[15] = '{373, 1'b0, 0, 0};
    vecs[16] = '{373, 1'b1, 7, 1};
    vecs[17] = '{332, 1'b1, 7, 0};
    vecs[18] = '{332, 1'b0, 0, 0};
    vecs[19] = '{332, 1'b0, 0, 0};
    vecs[20] = '{332, 1'b0, 0, 0};
    vecs[21] = '{TIMEOUT + 50, 1'b1, 8, 1};

    repeat (4) @(negedge clk);
    cmp("reset note_valid", int'(note_valid), 0);
    cmp("reset note", int'(note), 0);
    cmp("reset note_changed", int'(note_changed), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    cmp("idle note_valid", int'(note_valid), 0);

    for (int i = 0; i < 6; i++)
      toggle($sformatf("a4[%0d]", i), vecs[i].gap, vecs[i].ev, vecs[i].en, vecs[i].echg);

    // Silence: valid must fall exactly TIMEOUT cycles after the last edge pulse
    repeat (EDGE_LAT + TIMEOUT - 1 - CHECK_DLY) @(negedge clk);
    cmp("silence before timeout", int'(note_valid), 1);
    @(negedge clk);
    cmp("silence at timeout", int'(note_valid), 0);
    repeat (20) @(negedge clk);

    for (int i = 6; i < 22; i++)
      toggle($sformatf("vec[%0d]", i), vecs[i].gap, vecs[i].ev, vecs[i].en, vecs[i].echg);

    // Reset during SCAN, then confirm the first edge only re-arms
    for (int i = 0; i < 6; i++)
      toggle($sformatf("pre_rst[%0d]", i), 443, (i >= 4), 5, (i == 4) ? 1 : 0);
    tone_in = ~tone_in;
    repeat (EDGE_LAT + 2) @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("mid-scan reset note_valid", int'(note_valid), 0);
    cmp("mid-scan reset note", int'(note), 0);
    cmp("mid-scan reset note_changed", int'(note_changed), 0);
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chg_mark = chg_cnt;
    for (int i = 0; i < 5; i++)
      toggle($sformatf("post_rst[%0d]", i), (i == 4) ? TIMEOUT + 50 : 443,
             (i == 4), 5, (i == 4) ? 1 : 0);

    // Single-cycle glitch inside an E4 half-period (593 = 151975 >> 8)
    for (int i = 0; i < 5; i++)
      toggle($sformatf("e4[%0d]", i), (i == 4) ? 200 : 593, (i == 4), 2, (i == 4) ? 1 : 0);
    tone_in = ~tone_in;
    @(negedge clk);
    tone_in = ~tone_in;
    repeat (99) @(negedge clk);
    cmp("glitch note_valid", int'(note_valid), EXP_GLITCH_V);
    if (note_valid) cmp("glitch note", int'(note), 2);
    repeat (TIMEOUT) @(negedge clk);
    cmp("glitch then silence", int'(note_valid), 0);
    cmp("glitch pulses", chg_cnt - chg_mark, 0);
    chg_mark = chg_cnt;

    // Randomised half-periods against the reference model
    hist.delete();
    m_armed  = 1'b0;
    m_valid  = 1'b0;
    prev_gap = TIMEOUT;
    cur      = $urandom_range(0, 15);
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) gap = TIMEOUT - 1;
      else if (r == 1) gap = TIMEOUT;
      else if (r <= 3) gap = $urandom_range(100, 700);
      else begin
        if (r == 4) cur = $urandom_range(0, 15);
        e   = full_hp[cur] >> HP_SHIFT;
        tol = e >> TOL_SHIFT;
        gap = e - (tol + 2) + int'($urandom_range(0, 2 * tol + 4));
      end
      model_edge(prev_gap, mv, mn, mc);
      toggle($sformatf("rand[%0d] gap_before=%0d", i, prev_gap), gap, mv, mn, mc);
      prev_gap = gap;
    end

    cmp("note_changed alignment errors", chg_misplaced, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
